// File: rtl/product_bcd_conv.sv
// Sequential shift-and-add-3 binary-to-BCD converter for the multiplier product.
// A rising edge of done_in captures bin_in; W cycles later bcd_out holds the result and valid rises.
module product_bcd_conv #(
  parameter int W      = 16,
  parameter int DIGITS = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  done_in,
  input  logic [W-1:0]          bin_in,
  output logic                  busy,
  output logic                  valid,
  output logic [4*DIGITS-1:0]   bcd_out
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] LAST_CNT = CW'(W - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                state_reg;
  logic                  done_q_reg;
  logic [W-1:0]          bin_sh_reg;
  logic [4*DIGITS-1:0]   bcd_sh_reg;
  logic [4*DIGITS-1:0]   bcd_out_reg;
  logic [CW-1:0]         cnt_reg;
  logic                  busy_reg;
  logic                  valid_reg;

  logic                  start;
  logic [4*DIGITS-1:0]   bcd_adj;
  logic [4*DIGITS-1:0]   bcd_next;
  logic                  unused_top_bit;

  assign start = done_in & ~done_q_reg;

  // Per-digit add-3 correction; digits are independent, no carry between them.
  generate
    for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
      assign bcd_adj[4*gi +: 4] = (bcd_sh_reg[4*gi +: 4] >= 4'd5)
                                  ? bcd_sh_reg[4*gi +: 4] + 4'd3
                                  : bcd_sh_reg[4*gi +: 4];
    end
  endgenerate

  // The digit-count constraint keeps the top bit zero, so dropping it is lossless.
  assign bcd_next       = {bcd_adj[4*DIGITS-2:0], bin_sh_reg[W-1]};
  assign unused_top_bit = bcd_adj[4*DIGITS-1];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      done_q_reg  <= 1'b1;
      bin_sh_reg  <= '0;
      bcd_sh_reg  <= '0;
      bcd_out_reg <= '0;
      cnt_reg     <= '0;
      busy_reg    <= 1'b0;
      valid_reg   <= 1'b0;
    end else begin
      done_q_reg <= done_in;
      case (state_reg)
        IDLE, DONE: begin
          if (start) begin
            state_reg  <= SHIFT;
            bin_sh_reg <= bin_in;
            bcd_sh_reg <= '0;
            cnt_reg    <= '0;
            busy_reg   <= 1'b1;
            valid_reg  <= 1'b0;
          end
        end
        SHIFT: begin
          bcd_sh_reg <= bcd_next;
          bin_sh_reg <= {bin_sh_reg[W-2:0], 1'b0};
          cnt_reg    <= cnt_reg + 1'b1;
          if (cnt_reg == LAST_CNT) begin
            state_reg   <= DONE;
            bcd_out_reg <= bcd_next;
            busy_reg    <= 1'b0;
            valid_reg   <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
          busy_reg  <= 1'b0;
          valid_reg <= 1'b0;
        end
      endcase
    end
  end

  assign busy    = busy_reg;
  assign valid   = valid_reg;
  assign bcd_out = bcd_out_reg;

endmodule

// File: tb/tb_product_bcd_conv.sv
// Self-checking bench for product_bcd_conv: constant vectors, corner sequences and random values
// checked against a decimal-arithmetic reference.
module tb_product_bcd_conv;

  localparam int W      = 16;
  localparam int DIGITS = 5;

  logic                clk;
  logic                rst;
  logic                done_in;
  logic [W-1:0]        bin_in;
  logic                busy;
  logic                valid;
  logic [4*DIGITS-1:0] bcd_out;

  int tests_run;
  int tests_failed;

  product_bcd_conv #(.W(W), .DIGITS(DIGITS)) dut (
    .clk     (clk),
    .rst     (rst),
    .done_in (done_in),
    .bin_in  (bin_in),
    .busy    (busy),
    .valid   (valid),
    .bcd_out (bcd_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]        bin;
    logic [4*DIGITS-1:0] bcd;
  } vec_t;

  vec_t vecs[10];

  // Decimal digits by plain division, packed units-first.
  function automatic logic [4*DIGITS-1:0] ref_bcd(input int unsigned v);
    logic [4*DIGITS-1:0] r;
    int unsigned x;
    r = '0;
    x = v;
    for (int d = 0; d < DIGITS; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full conversion from a fresh done_in rising edge; returns result and busy-sample count.
  task automatic run_conv(input logic [W-1:0] b, output logic [4*DIGITS-1:0] res,
                          output int busy_n, output bit ok);
    bit overlap;
    done_in = 1'b0;
    step();
    bin_in  = b;
    done_in = 1'b1;
    step();
    ok = (busy === 1'b1) && (valid === 1'b0);
    busy_n  = 0;
    overlap = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (busy && valid) overlap = 1'b1;
      if (busy !== 1'b1) break;
      busy_n++;
      step();
    end
    if (overlap || valid !== 1'b1) ok = 1'b0;
    res     = bcd_out;
    done_in = 1'b0;
  endtask

  initial begin
    logic [4*DIGITS-1:0] res;
    logic [W-1:0]        rv;
    int                  bn;
    bit                  ok;
    int                  bad;
    int                  busy_total;

    tests_run    = 0;
    tests_failed = 0;

    vecs[0] = '{16'd65535, 20'h65535};
    vecs[1] = '{16'd9,     20'h00009};
    vecs[2] = '{16'd10,    20'h00010};
    vecs[3] = '{16'd99,    20'h00099};
    vecs[4] = '{16'd100,   20'h00100};
    vecs[5] = '{16'd1,     20'h00001};
    vecs[6] = '{16'd4095,  20'h04095};
    vecs[7] = '{16'd50000, 20'h50000};
    vecs[8] = '{16'd59999, 20'h59999};
    vecs[9] = '{16'd32768, 20'h32768};

    rst     = 1'b1;
    done_in = 1'b0;
    bin_in  = '0;
    step();
    step();
    rst = 1'b0;
    check("reset_busy",  32'(busy),    32'd0);
    check("reset_valid", 32'(valid),   32'd0);
    check("reset_bcd",   32'(bcd_out), 32'd0);

    // Zero input: exact busy length and result.
    run_conv(16'd0, res, bn, ok);
    $display("[TB] conv bin=0 -> bcd=%05h busy_cycles=%0d", res, bn);
    check("zero_bcd",     32'(res), 32'h00000);
    check("zero_busy_n",  32'(bn),  32'd16);
    check("zero_handshake", 32'(ok), 32'd1);

    for (int i = 0; i < 10; i++) begin
      run_conv(vecs[i].bin, res, bn, ok);
      $display("[TB] conv bin=%0d -> bcd=%05h busy_cycles=%0d", vecs[i].bin, res, bn);
      check($sformatf("vec%0d_bcd", i),   32'(res), 32'(vecs[i].bcd));
      check($sformatf("vec%0d_busy", i),  32'(bn),  32'd16);
      check($sformatf("vec%0d_hs", i),    32'(ok),  32'd1);
    end

    // done_in held high for 100 cycles: one conversion, stable result.
    done_in = 1'b0;
    step();
    bin_in  = 16'd1234;
    done_in = 1'b1;
    busy_total = 0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (busy) busy_total++;
      if (i >= 16 && (valid !== 1'b1 || bcd_out !== 20'h01234)) bad++;
    end
    $display("[TB] held bin=1234 -> bcd=%05h busy_cycles=%0d unstable=%0d", bcd_out, busy_total, bad);
    check("held_busy_n",   32'(busy_total), 32'd16);
    check("held_unstable", 32'(bad),        32'd0);
    check("held_bcd",      32'(bcd_out),    32'h01234);
    done_in = 1'b0;

    // Second start pulse at k+5 must be dropped.
    step();
    bin_in  = 16'd42;
    done_in = 1'b1;
    step();
    done_in = 1'b0;
    bin_in  = 16'd77;
    for (int i = 1; i <= 4; i++) step();
    done_in = 1'b1;
    for (int i = 5; i <= 15; i++) step();
    check("dup_valid_k15", 32'(valid), 32'd0);
    step();
    $display("[TB] dup bin=42/77 -> bcd=%05h valid=%0b busy=%0b", bcd_out, valid, busy);
    check("dup_valid_k16", 32'(valid),   32'd1);
    check("dup_busy_k16",  32'(busy),    32'd0);
    check("dup_bcd",       32'(bcd_out), 32'h00042);
    step();
    step();
    check("dup_no_restart", 32'(busy), 32'd0);
    done_in = 1'b0;

    // Reset in the middle of a conversion.
    step();
    bin_in  = 16'd555;
    done_in = 1'b1;
    step();
    for (int i = 1; i <= 7; i++) step();
    rst = 1'b1;
    step();
    rst     = 1'b0;
    done_in = 1'b0;
    $display("[TB] midreset -> busy=%0b valid=%0b bcd=%05h", busy, valid, bcd_out);
    check("midrst_busy",  32'(busy),    32'd0);
    check("midrst_valid", 32'(valid),   32'd0);
    check("midrst_bcd",   32'(bcd_out), 32'd0);
    run_conv(16'd300, res, bn, ok);
    $display("[TB] conv bin=300 -> bcd=%05h busy_cycles=%0d", res, bn);
    check("post_rst_bcd", 32'(res), 32'h00300);
    check("post_rst_hs",  32'(ok),  32'd1);

    // done_in high across reset release: no conversion.
    done_in = 1'b1;
    bin_in  = 16'd777;
    rst     = 1'b1;
    step();
    step();
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      step();
      if (busy !== 1'b0 || valid !== 1'b0) bad++;
    end
    $display("[TB] done held across reset -> bad_cycles=%0d", bad);
    check("rst_level_no_start", 32'(bad), 32'd0);
    done_in = 1'b0;

    // Random values against the decimal reference.
    for (int i = 0; i < 30; i++) begin
      rv = 16'($urandom_range(0, 65535));
      run_conv(rv, res, bn, ok);
      $display("[TB] conv bin=%0d -> bcd=%05h busy_cycles=%0d", rv, res, bn);
      check($sformatf("rand%0d_bcd", i), 32'(res), 32'(ref_bcd(32'(rv))));
      check($sformatf("rand%0d_hs", i),  32'(ok && bn == 16), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
